dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data memory (combinational read, synchronous write) between the RISC-V core and a host/debug port used for program inspection and data loading. The core has priority. The host is served in cycles where the core makes no data access. A starvation counter forces a one-cycle core stall when the host has waited too long. The block sits between `core_top`, the host port and `dmem`; `core_top` gains a `stall` input driven by `core_stall`.

## Interface
- `STARVE_MAX`, default 4: number of host wait cycles before a core stall is forced; legal range 1..255.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `core_we` in 1: core store.
- `core_re` in 1: core load.
- `core_addr` in AW: core byte address (ALU result).
- `core_wdata` in DW: core store data.
- `core_rdata` out DW: load data to core.
- `core_stall` out 1: core must hold PC and register state this cycle.
- `host_valid` in 1: host request valid.
- `host_ready` out 1: host request accepted this cycle.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in AW: host address.
- `host_wdata` in DW: host write data.
- `host_rvalid` out 1: host read data valid, one-cycle pulse.
- `host_rdata` out DW: host read data.
- `mem_we` out 1: dmem write enable.
- `mem_a` out AW: dmem address.
- `mem_wd` out DW: dmem write data.
- `mem_rd` in DW: dmem combinational read data.

## Operation
- `core_busy = core_we | core_re`.
- States: IDLE and RESP.
  - IDLE → RESP on a host read accept.
  - RESP → IDLE unconditionally after 1 cycle.
  - A host write accept stays in IDLE.
- Grant (combinational): `host_ready = (state==IDLE) & host_valid & (!core_busy | wait_cnt==STARVE_MAX)`.
- `core_stall = host_ready & core_busy`.
- When `host_ready` is high, the mem port carries host fields: `mem_we = host_we`, `mem_a = host_addr`, `mem_wd = host_wdata`.
- Otherwise the mem port carries core fields: `mem_we = core_we`, `mem_a = core_addr`, `mem_wd = core_wdata`.
- A core store is never issued to memory in a stall cycle.
- `core_rdata = mem_rd` always. It is only meaningful when `!core_stall`.
- Host read: `mem_rd` is registered into `host_rdata` in the accept cycle. `host_rvalid` = 1 for the following cycle. `host_rdata` holds its value until the next host read.
- `wait_cnt` (8-bit):
  - Clears on a host accept and whenever `!host_valid`.
  - Increments while `host_valid & !host_ready & state==IDLE`.
  - Saturates at `STARVE_MAX`.
- Only one host read is outstanding at a time. `host_ready` = 0 in RESP, so back-to-back host reads take 2 cycles each.
- Host writes can be accepted every cycle.
- Host request fields must stay stable while `host_valid & !host_ready`. `host_valid` must not be withdrawn before acceptance.
- Simultaneous core access and host request with `wait_cnt < STARVE_MAX`: the core wins and the host waits.
- Simultaneous accesses to the same address: accesses are serialised, and the later cycle sees the earlier write.

## Timing
- Reset values: state = IDLE, `wait_cnt` = 0, `host_rvalid` = 0, `host_rdata` = 0.
- All combinational outputs follow from the reset state: `host_ready` and `core_stall` are 0 unless `host_valid` is high.
- Host read latency: accept at cycle N, `host_rvalid` and data at cycle N+1.
- Host write: committed at the clock edge ending the accept cycle.
- Core path: zero added latency. The mux is combinational, so the single-cycle core is preserved.
- Worst-case host wait under continuous core access: `STARVE_MAX` cycles, then accepted with exactly one stall cycle.
- Reset asserted mid-operation: a pending `host_rvalid` is dropped, `wait_cnt` clears, and no write is issued during reset.

## Structure
- Package `dmem_arb_pkg` contains:
  - `arb_state_t` enum (IDLE, RESP).
  - `host_req_t` struct (`we`, `addr`, `wdata`).
  - Localparam `WAIT_CNT_W` = 8.
- One natural sub-module, `arb_starve_cnt`: the saturating wait counter with `clear`/`inc` inputs and an `at_max` output.
- Everything else, including the mux, FSM and read register, stays in `dmem_arbiter`.

## Test plan
- Core idle; host writes 0xDEADBEEF to 0x40, then reads 0x40 → `host_ready` high in both accept cycles, `host_rvalid` 1 cycle after the read with `host_rdata` = 0xDEADBEEF, `core_stall` never asserted.
- Core stores continuously; host read of 0x40 pending from cycle 0 with `STARVE_MAX` = 4 → `host_ready` and `core_stall` both high at cycle 4 only, with no core store reaching memory that cycle.
- Core store 0x11 to 0x80 and host read of 0x80 requested in the same cycle with core priority → host accepted next idle cycle and returns 0x11.
- Host issues back-to-back reads of 0x0 and 0x4 with core idle → accepts at cycles 0 and 2, `host_rvalid` at cycles 1 and 3, `host_ready` low in cycle 1.
- Reset asserted the cycle after a host read accept → `host_rvalid` = 0, state IDLE, `wait_cnt` 0; the next request is served normally.
- Random core and host traffic with a scoreboard memory model → no lost or duplicated writes, all host reads match the model, and no host wait exceeds `STARVE_MAX` cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter between the core and the host/debug port.
package dmem_arb_pkg;

    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE,
        RESP
    } arb_state_t;

    // Sized for the default 32-bit address/data configuration.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } host_req_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles the host has been kept waiting by core traffic.
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + WAIT_CNT_W'(1);
        end
    end

    assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core (priority) and a host port, with a starvation-forced core stall.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic          core_re,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    arb_state_t state, state_next;
    logic       core_busy;
    logic       wait_at_max;
    logic       cnt_clear;
    logic       cnt_inc;
    logic       host_rd_accept;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .at_max (wait_at_max)
    );

    always_comb begin
        core_busy      = core_we | core_re;
        // Gated by reset so an accepted host write can never be silently dropped.
        host_ready     = !reset && (state == IDLE) && host_valid && (!core_busy || wait_at_max);
        core_stall     = host_ready & core_busy;
        host_rd_accept = host_ready & !host_we;
        cnt_clear      = host_ready | !host_valid;
        cnt_inc        = host_valid & !host_ready & (state == IDLE);
        host_rvalid    = (state == RESP);
        core_rdata     = mem_rd;

        state_next = state;
        case (state)
            IDLE:    if (host_rd_accept) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (host_ready) begin
            mem_we = host_we;
            mem_a  = host_addr;
            mem_wd = host_wdata;
        end else begin
            mem_we = core_we & !reset;
            mem_a  = core_addr;
            mem_wd = core_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata <= '0;
        end else if (host_rd_accept) begin
            host_rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a memory model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_we, core_re;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          host_valid, host_ready, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];

    dmem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .AW         (AW),
        .DW         (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_we     (core_we),
        .core_re     (core_re),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous write, word-indexed.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_a[9:2]] <= mem_wd;
    end
    assign mem_rd = tb_mem[mem_a[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset      = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h300;
        core_wdata = 32'hBAD0BAD0;
        host_valid = 1'b1;
        host_we    = 1'b1;
        tick();
        tick();
        #2;
        n_cmp++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
        n_cmp++; if (host_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", host_rdata); end
        n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
        n_cmp++; if (dut.u_starve_cnt.cnt !== 8'd0) begin n_fail++; $display("FAIL rst_wait_cnt: got %0d want 0", dut.u_starve_cnt.cnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        idle_inputs();
        tick();
        reset = 1'b0;
        #2;
        n_cmp++; if (host_ready !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: ready %b stall %b want 0 0", host_ready, core_stall); end
        n_cmp++; if (tb_mem[8'hC0] !== 32'h0) begin n_fail++; $display("FAIL rst_no_write: got %h want 0", tb_mem[8'hC0]); end
        tick();
    endtask

    task automatic test_write_read();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'hDEADBEEF;
        #2;
        n_cmp++; if (host_ready !== 1'b1 || core_stall !== 1'b0) begin n_fail++; $display("FAIL wr_accept: ready %b stall %b want 1 0", host_ready, core_stall); end
        n_cmp++; if (mem_we !== 1'b1 || mem_a !== 32'h40 || mem_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_memport: we %b a %h wd %h want 1 40 deadbeef", mem_we, mem_a, mem_wd); end
        tick();
        host_we = 1'b0; host_wdata = '0;
        #2;
        n_cmp++; if (host_ready !== 1'b1 || host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_accept: ready %b rvalid %b want 1 0", host_ready, host_rvalid); end
        tick();
        host_valid = 1'b0;
        #2;
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_resp: rvalid %b data %h want 1 deadbeef", host_rvalid, host_rdata); end
        n_cmp++; if (host_ready !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL rd_resp_ready: ready %b stall %b want 0 0", host_ready, core_stall); end
        tick();
        #2;
        n_cmp++; if (host_rvalid !== 1'b0 || host_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: rvalid %b data %h want 0 deadbeef", host_rvalid, host_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 5; c++) begin
            core_we = 1'b1; core_re = 1'b0;
            core_addr = 32'h100 + 32'(4 * c); core_wdata = 32'(c + 1);
            host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h40;
            #2;
            n_cmp++; if (host_ready !== (c == 4) || core_stall !== (c == 4)) begin n_fail++; $display("FAIL starve_grant c%0d: ready %b stall %b want %b %b", c, host_ready, core_stall, (c == 4), (c == 4)); end
            n_cmp++; if (mem_we !== (c != 4)) begin n_fail++; $display("FAIL starve_mem_we c%0d: got %b want %b", c, mem_we, (c != 4)); end
            tick();
        end
        host_valid = 1'b0; core_we = 1'b0;
        #2;
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_resp: rvalid %b data %h want 1 deadbeef", host_rvalid, host_rdata); end
        n_cmp++; if (tb_mem[8'h44] !== 32'h0 || tb_mem[8'h43] !== 32'h4) begin n_fail++; $display("FAIL starve_store: w110 %h w10c %h want 0 4", tb_mem[8'h44], tb_mem[8'h43]); end
        tick();
    endtask

    task automatic test_core_priority();
        core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h11;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h80;
        #2;
        n_cmp++; if (host_ready !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b1) begin n_fail++; $display("FAIL prio_core: ready %b stall %b mem_we %b want 0 0 1", host_ready, core_stall, mem_we); end
        tick();
        core_we = 1'b0;
        #2;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL prio_host_next: ready %b want 1", host_ready); end
        tick();
        host_valid = 1'b0;
        #2;
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h11) begin n_fail++; $display("FAIL prio_data: rvalid %b data %h want 1 11", host_rvalid, host_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 32'h0; host_wdata = 32'hA0A0A0A0;
        #2;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr0: ready %b want 1", host_ready); end
        tick();
        host_addr = 32'h4; host_wdata = 32'hB1B1B1B1;
        #2;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr1: ready %b want 1", host_ready); end
        tick();
        host_we = 1'b0; host_addr = 32'h0; host_wdata = '0;
        #2;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rd0_accept: ready %b want 1", host_ready); end
        tick();
        host_addr = 32'h4;
        #2;
        n_cmp++; if (host_ready !== 1'b0 || host_rvalid !== 1'b1 || host_rdata !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL b2b_cyc1: ready %b rvalid %b data %h want 0 1 a0a0a0a0", host_ready, host_rvalid, host_rdata); end
        tick();
        #2;
        n_cmp++; if (host_ready !== 1'b1 || host_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_cyc2: ready %b rvalid %b want 1 0", host_ready, host_rvalid); end
        tick();
        host_valid = 1'b0;
        #2;
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL b2b_cyc3: rvalid %b data %h want 1 b1b1b1b1", host_rvalid, host_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h80;
        #2;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: ready %b want 1", host_ready); end
        tick();
        host_valid = 1'b0;
        core_we = 1'b1; core_addr = 32'h84; core_wdata = 32'h55;
        reset = 1'b1;
        #2;
        n_cmp++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_rvalid: rvalid %b data %h want 0 0", host_rvalid, host_rdata); end
        n_cmp++; if (dut.state !== IDLE || dut.u_starve_cnt.cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_state: state %0d cnt %0d want IDLE 0", dut.state, dut.u_starve_cnt.cnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_we: got %b want 0", mem_we); end
        @(negedge clk);
        core_we = 1'b0;
        reset = 1'b0;
        tick();
        #2;
        n_cmp++; if (tb_mem[8'h21] !== 32'h0) begin n_fail++; $display("FAIL rmid_no_write: got %h want 0", tb_mem[8'h21]); end
        host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h80;
        #1;
        n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reaccept: ready %b want 1", host_ready); end
        tick();
        host_valid = 1'b0;
        #2;
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h11) begin n_fail++; $display("FAIL rmid_resp: rvalid %b data %h want 1 11", host_rvalid, host_rdata); end
        tick();
    endtask

    task automatic test_random();
        host_req_t   req;
        logic        pend;
        logic        resp_next;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        busy, exp_ready, exp_stall;
        int          waited;
        int          obs_wait;
        int          r;
        int          bad_words;

        // Known contents for the 64 words random traffic touches.
        for (int w = 0; w < 64; w++) begin
            host_valid = 1'b1; host_we = 1'b1;
            host_addr = 32'(w) * 4; host_wdata = $urandom;
            ref_mem[w] = host_wdata;
            #2;
            n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_prefill w%0d: ready %b want 1", w, host_ready); end
            tick();
        end
        idle_inputs();

        pend = 1'b0; resp_next = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;
        waited = 0; obs_wait = 0; req = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend       = 1'b1;
                req.we     = 1'($urandom_range(0, 1));
                req.addr   = 32'($urandom_range(0, 63)) * 4;
                req.wdata  = $urandom;
                waited     = 0;
                obs_wait   = 0;
            end
            r          = int'($urandom_range(0, 9));
            core_we    = (r < 3);
            core_re    = (r >= 3) && (r < 6);
            core_addr  = 32'($urandom_range(0, 63)) * 4;
            core_wdata = $urandom;
            host_valid = pend;
            host_we    = req.we;
            host_addr  = req.addr;
            host_wdata = req.wdata;
            #2;
            busy      = core_we | core_re;
            exp_ready = pend && !resp_next && (!busy || waited >= int'(STARVE_MAX));
            exp_stall = exp_ready && busy;
            n_cmp++; if (host_ready !== exp_ready || core_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_grant cyc%0d: ready %b stall %b want %b %b", cyc, host_ready, core_stall, exp_ready, exp_stall); end
            n_cmp++; if (host_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc%0d: got %b want %b", cyc, host_rvalid, exp_rvalid); end
            if (exp_rvalid) begin
                n_cmp++; if (host_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_hdata cyc%0d: got %h want %h", cyc, host_rdata, exp_rdata); end
            end
            if (core_re && !exp_stall) begin
                n_cmp++; if (core_rdata !== ref_mem[core_addr[9:2]]) begin n_fail++; $display("FAIL rnd_cdata cyc%0d: got %h want %h", cyc, core_rdata, ref_mem[core_addr[9:2]]); end
            end
            if (pend && host_ready) begin
                n_cmp++; if (obs_wait > int'(STARVE_MAX)) begin n_fail++; $display("FAIL rnd_wait cyc%0d: waited %0d want <= %0d", cyc, obs_wait, STARVE_MAX); end
            end
            if (pend && !host_ready && !host_rvalid) obs_wait++;

            exp_rvalid = exp_ready && !req.we;
            if (exp_rvalid) exp_rdata = ref_mem[req.addr[9:2]];
            if (exp_ready && req.we) ref_mem[req.addr[9:2]] = req.wdata;
            else if (!exp_ready && core_we) ref_mem[core_addr[9:2]] = core_wdata;
            if (pend && !exp_ready && !resp_next) waited++;
            if (exp_ready) pend = 1'b0;
            resp_next = exp_rvalid;
            tick();
        end
        idle_inputs();
        #2;
        n_cmp++; if (host_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_drain: rvalid %b want %b", host_rvalid, exp_rvalid); end
        tick();
        bad_words = 0;
        for (int w = 0; w < 64; w++) begin
            if (tb_mem[w] !== ref_mem[w]) bad_words++;
        end
        n_cmp++; if (bad_words != 0) begin n_fail++; $display("FAIL rnd_memory: %0d words differ, want 0", bad_words); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_read();
        test_starvation();
        test_core_priority();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
